bcd_conv: RTL and testbench

BCD_CONV -- requirements
Module: bcd_conv

---
 rtl/bcd_conv.sv | 118 +++++++++++
 tb/tb_bcd_conv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_conv
//  Description : Sequential binary-to-BCD converter (shift-and-add-3).
//                A start request captures bin, then WIDTH shift steps run,
//                then one finish step publishes the packed BCD result on bcd
//                with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int c_CW = $clog2(WIDTH + 1);
    localparam int c_BW = 4 * DIGITS;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_bin, w_bin_nxt;
    logic [c_BW-1:0]     r_scratch, w_scratch_nxt;
    logic [c_CW-1:0]     r_cnt, w_cnt_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic [c_BW-1:0]     r_bcd, w_bcd_nxt;
    logic [c_BW-1:0]     w_adj;

    // Per-digit add-3 correction applied before every shift
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                     (r_scratch[4*g +: 4] + 4'd3) :
                                     r_scratch[4*g +: 4];
        end
    endgenerate

    // State and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bin     <= w_bin_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_bcd     <= w_bcd_nxt;
        end
    end

    // Next-state and next-datapath logic; busy covers the shift phase only
    always_comb begin
        w_state_nxt   = r_state;
        w_bin_nxt     = r_bin;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_bcd_nxt     = r_bcd;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_bin_nxt     = bin;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_scratch_nxt = {w_adj[c_BW-2:0], r_bin[WIDTH-1]};
                w_bin_nxt     = {r_bin[WIDTH-2:0], 1'b0};
                w_cnt_nxt     = r_cnt + c_ONE;
                if (r_cnt == c_LAST) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_bcd_nxt   = r_scratch;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_conv
//  Description : Self-checking bench for bcd_conv against a decimal model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_conv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;

    int          n_vec;
    int          n_err;
    logic [15:0] model_last;

    bcd_conv #(.WIDTH(12), .DIGITS(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Decimal reference: each nibble is one base-10 digit of n
    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int d;
        r = '0;
        d = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((n / d) % 10);
            d = d * 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion over a fixed 31-edge window, called at a negedge.
    task automatic do_conv(input logic [11:0] v, input int chg_edge,
                           input logic [11:0] chg_val, input int restart_edge,
                           input string tag);
        logic [15:0] exp;
        logic [15:0] held;
        int lat, bcyc, dones, bchg;
        exp   = to_bcd(int'(v));
        held  = model_last;
        lat   = -1;
        bcyc  = 0;
        dones = 0;
        bchg  = 0;
        start = 1'b1;
        bin   = v;
        for (int k = 0; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dones++;
                if (lat < 0) lat = k;
                held = exp;
            end
            if (busy) bcyc++;
            if (bcd !== held) bchg++;
            start = ((k + 1) == restart_edge);
            if ((k + 1) == chg_edge) bin = chg_val;
        end
        model_last = exp;
        chk({tag, ".latency"},  32'(lat),   32'd13);
        chk({tag, ".dones"},    32'(dones), 32'd1);
        chk({tag, ".busycyc"},  32'(bcyc),  32'd12);
        chk({tag, ".bcdhold"},  32'(bchg),  32'd0);
        chk({tag, ".bcd"},      32'(bcd),   32'(exp));
    endtask

    initial begin
        int d1, d2, nd, lat;
        logic [15:0] r1, r2;
        logic got, ok;

        n_vec      = 0;
        n_err      = 0;
        model_last = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        bin        = '0;

        // Reset state
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.bcd",  32'(bcd),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        do_conv(12'd0,    -1, 12'd0, -1, "zero");
        do_conv(12'd4095, -1, 12'd0, -1, "full");
        do_conv(12'd3969,  3, 12'd5, -1, "binchg");
        do_conv(12'd999,  -1, 12'd0,  5, "restart");

        // Back-to-back with start held high
        d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        start = 1'b1;
        bin   = 12'd10;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = k; r1 = bcd;
                end else if (d2 < 0) begin
                    d2 = k; r2 = bcd; start = 1'b0;
                end
            end
            if (k == 0) bin = 12'd100;
        end
        start = 1'b0;
        model_last = to_bcd(100);
        chk("b2b.first",   32'(d1),      32'd13);
        chk("b2b.spacing", 32'(d2 - d1), 32'd14);
        chk("b2b.bcd1",    32'(r1),      32'(to_bcd(10)));
        chk("b2b.bcd2",    32'(r2),      32'(to_bcd(100)));
        // Let any stray conversion finish without interfering
        repeat (16) @(negedge clk);

        // Reset in the middle of a conversion
        start = 1'b1;
        bin   = 12'd1234;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.bcd",  32'(bcd),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = '0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst.nodone", 32'(nd), 32'd0);
        do_conv(12'd1234, -1, 12'd0, -1, "postrst");

        // Randomized conversions with bin disturbance and ignored restarts
        for (int i = 0; i < 8; i++) begin
            do_conv(12'($urandom_range(0, 4095)), int'($urandom_range(1, 12)),
                    12'($urandom), int'($urandom_range(1, 13)), "rand");
        end

        // Exhaustive sweep with bin scrambled every busy cycle
        for (int v = 0; v < 4096; v++) begin
            start = 1'b1;
            bin   = 12'(v);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            got = 1'b0;
            lat = 0;
            for (int c = 1; c <= 20; c++) begin
                bin = 12'($urandom);
                @(posedge clk);
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    lat = c;
                    break;
                end
            end
            chk("sweep.latency", 32'(lat), 32'd13);
            chk("sweep.bcd",     32'(bcd), 32'(to_bcd(v)));
            ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (bcd[4*i +: 4] > 4'd9) ok = 1'b0;
            end
            chk("sweep.nibble", 32'(ok && got), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
